// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV32M constants and M-op sequencer state encoding.
// Contents: M-extension funct7, funct3 op codes, sequencer FSM states.
package riscv_pkg;
    localparam logic [6:0] F7_MEXT   = 7'b0000001;
    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2} state_t;
endpackage

// File: rtl/ex_muldiv_seq_muldiv_step.sv
// muldiv_step: one combinational iteration of shift-add multiply or restoring divide.
// Ports: i_div selects divide; i_acc is {product hi, multiplier} or {unused, dividend/quotient};
//        i_rem is the partial remainder; i_b is multiplicand/divisor; o_acc/o_rem are next values.
module muldiv_step #(
    parameter int XLEN = 32
) (
    input  logic              i_div,
    input  logic [2*XLEN-1:0] i_acc,
    input  logic [XLEN:0]     i_rem,
    input  logic [XLEN-1:0]   i_b,
    output logic [2*XLEN-1:0] o_acc,
    output logic [XLEN:0]     o_rem
);
    logic [XLEN:0] w_sum, w_shift, w_diff;
    always_comb begin
        w_sum   = {1'b0, i_acc[2*XLEN-1:XLEN]} + (i_acc[0] ? {1'b0, i_b} : '0);
        // remainder < divisor, so the shifted value always fits in XLEN+1 bits
        w_shift = {i_rem[XLEN-1:0], i_acc[XLEN-1]};
        w_diff  = w_shift - {1'b0, i_b};
        o_acc   = i_div ? {i_acc[2*XLEN-1:XLEN], i_acc[XLEN-2:0], ~w_diff[XLEN]}
                        : {w_sum, i_acc[XLEN-1:1]};
        o_rem   = i_div ? (w_diff[XLEN] ? w_shift : w_diff) : i_rem;
    end
endmodule

// File: rtl/ex_muldiv_seq.sv
// ex_muldiv_seq: iterative RV32M multiply/divide sequencer beside the EX-stage ALU.
// Ports: clk, rst (sync active-high); start/funct3/op_a/op_b from ID/EX; flush kills the op;
//        stall freezes the front end; done/result present the result for one cycle.
// Option: define MULDIV_FAST_MUL_EN for a single-cycle combinational multiplier.
module ex_muldiv_seq
    import riscv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result
);
    state_t            r_state, w_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [2:0]        r_f3;
    logic              r_sa, r_sb, r_spec;
    logic [XLEN-1:0]   r_b, r_spec_val;
    logic [2*XLEN-1:0] r_acc, w_acc_nx, w_prod, w_pfix;
    logic [XLEN:0]     r_rem, w_rem_nx;
    logic              w_accept, w_sa, w_sb, w_divz, w_ovf, w_spec, w_fast;
    logic [XLEN-1:0]   w_abs_a, w_abs_b, w_spec_val, w_qfix, w_rfix, w_res;

    assign w_accept   = r_state == S_IDLE && start && !flush;
    assign w_sa       = op_a[XLEN-1] && (funct3 == F3_MULH || funct3 == F3_MULHSU ||
                                         funct3 == F3_DIV  || funct3 == F3_REM);
    assign w_sb       = op_b[XLEN-1] && (funct3 == F3_MULH || funct3 == F3_DIV || funct3 == F3_REM);
    assign w_abs_a    = w_sa ? -op_a : op_a;
    assign w_abs_b    = w_sb ? -op_b : op_b;
    assign w_divz     = funct3[2] && op_b == '0;
    assign w_ovf      = funct3[2] && !funct3[0] && op_a == {1'b1, {(XLEN-1){1'b0}}} && op_b == '1;
    assign w_spec     = w_divz || w_ovf;
    assign w_spec_val = w_divz ? (funct3[1] ? op_a : '1) : (funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}});
`ifdef MULDIV_FAST_MUL_EN
    assign w_fast     = !funct3[2];
    assign w_prod     = {{XLEN{1'b0}}, r_acc[XLEN-1:0]} * {{XLEN{1'b0}}, r_b};
`else
    assign w_fast     = 1'b0;
    assign w_prod     = r_acc;
`endif

    muldiv_step #(.XLEN(XLEN)) u_step (
        .i_div(r_f3[2]),
        .i_acc(r_acc),
        .i_rem(r_rem),
        .i_b  (r_b),
        .o_acc(w_acc_nx),
        .o_rem(w_rem_nx)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = flush                ? S_IDLE :
                 r_state == S_IDLE    ? (start ? ((w_spec || w_fast) ? S_DONE : S_BUSY) : S_IDLE) :
                 r_state == S_BUSY    ? (r_cnt == CNT_W'(XLEN-1) ? S_DONE : S_BUSY) :
                                        S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= '0;
            r_f3       <= '0;
            r_sa       <= 1'b0;
            r_sb       <= 1'b0;
            r_spec     <= 1'b0;
            r_spec_val <= '0;
            r_b        <= '0;
            r_acc      <= '0;
            r_rem      <= '0;
        end else if (w_accept) begin
            r_cnt      <= '0;
            r_f3       <= funct3;
            r_sa       <= w_sa;
            r_sb       <= w_sb;
            r_spec     <= w_spec;
            r_spec_val <= w_spec_val;
            r_b        <= w_abs_b;
            r_acc      <= {{XLEN{1'b0}}, w_abs_a};
            r_rem      <= '0;
        end else if (r_state == S_BUSY) begin
            r_cnt      <= r_cnt + 1'b1;
            r_acc      <= w_acc_nx;
            r_rem      <= w_rem_nx;
        end
    end

    // the product is negated at full width so MULH variants see the correct high half
    assign w_pfix = (r_sa ^ r_sb) ? -w_prod : w_prod;
    assign w_qfix = (r_sa ^ r_sb) ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
    assign w_rfix = r_sa ? -r_rem[XLEN-1:0] : r_rem[XLEN-1:0];
    assign w_res  = r_spec ? r_spec_val :
                    r_f3[2] ? (r_f3[1] ? w_rfix : w_qfix) :
                    r_f3 == F3_MUL ? w_pfix[XLEN-1:0] : w_pfix[2*XLEN-1:XLEN];

    assign stall  = !rst && (w_accept || r_state == S_BUSY);
    assign done   = !rst && r_state == S_DONE;
    assign result = done ? w_res : '0;
endmodule
